// File: rtl/nios32_timer_host_if.sv
// Avalon-MM link between nios32_timer_host (master) and a nios32 interval timer s1 port (slave).
interface nios32_timer_host_if;
  logic [2:0]  tm_address;
  logic        tm_chipselect;
  logic        tm_write_n;
  logic [15:0] tm_writedata;
  logic [15:0] tm_readdata;
  logic        tm_irq;

  modport master (
    output tm_address, tm_chipselect, tm_write_n, tm_writedata,
    input  tm_readdata, tm_irq
  );

  modport slave (
    input  tm_address, tm_chipselect, tm_write_n, tm_writedata,
    output tm_readdata, tm_irq
  );
endinterface

// File: rtl/nios32_timer_host.sv
// Hardware owner of a nios32 interval timer: programs/starts/stops it and services its irq.
// Optional counter snapshot readback is enabled by `NIOS32_TIMER_HOST_SNAPSHOT_EN.
module nios32_timer_host #(
  parameter logic [31:0] DEFAULT_PERIOD = 32'd49999,
  parameter int          TICK_W         = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  use_default,
  input  logic [31:0]           period_in,
`ifdef NIOS32_TIMER_HOST_SNAPSHOT_EN
  input  logic                  snap_req,
  output logic [31:0]           snap_value,
  output logic                  snap_valid,
`endif
  nios32_timer_host_if.master   tm,
  output logic                  tick,
  output logic [TICK_W-1:0]     tick_count,
  output logic                  running,
  output logic                  busy
);

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, RUN, WR_STOP, WR_CLR, HOLD
`ifdef NIOS32_TIMER_HOST_SNAPSHOT_EN
    , SNAP_WR, SNAP_RL, SNAP_RH, SNAP_CAP
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         period_q, period_d, pend_per_q, pend_per_d, new_per;
  logic                pend_start_q, pend_start_d, pend_stop_q, pend_stop_d;
  logic [TICK_W-1:0]   cnt_q, cnt_d;
  logic [2:0]          addr_q, addr_d;
  logic                cs_q, cs_d, wn_q, wn_d;
  logic [15:0]         wd_q, wd_d;
  logic                tick_q, tick_d, running_q, running_d, busy_q, busy_d;
`ifdef NIOS32_TIMER_HOST_SNAPSHOT_EN
  logic [15:0]         snap_lo_q, snap_lo_d;
  logic [31:0]         snap_val_q, snap_val_d;
  logic                snap_vld_q, snap_vld_d;
`else
  logic                rd_unused;
  assign rd_unused = ^tm.tm_readdata;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      period_q     <= '0;
      pend_per_q   <= '0;
      pend_start_q <= 1'b0;
      pend_stop_q  <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      cs_q         <= 1'b0;
      wn_q         <= 1'b1;
      wd_q         <= '0;
      tick_q       <= 1'b0;
      running_q    <= 1'b0;
      busy_q       <= 1'b0;
`ifdef NIOS32_TIMER_HOST_SNAPSHOT_EN
      snap_lo_q    <= '0;
      snap_val_q   <= '0;
      snap_vld_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      pend_per_q   <= pend_per_d;
      pend_start_q <= pend_start_d;
      pend_stop_q  <= pend_stop_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      cs_q         <= cs_d;
      wn_q         <= wn_d;
      wd_q         <= wd_d;
      tick_q       <= tick_d;
      running_q    <= running_d;
      busy_q       <= busy_d;
`ifdef NIOS32_TIMER_HOST_SNAPSHOT_EN
      snap_lo_q    <= snap_lo_d;
      snap_val_q   <= snap_val_d;
      snap_vld_q   <= snap_vld_d;
`endif
    end
  end

  // Next state; commands arriving mid-sequence wait in a 1-deep pending slot (stop dominant).
  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    pend_per_d   = pend_per_q;
    pend_start_d = pend_start_q;
    pend_stop_d  = pend_stop_q;
    cnt_d        = cnt_q;
    new_per      = use_default ? DEFAULT_PERIOD : period_in;
`ifdef NIOS32_TIMER_HOST_SNAPSHOT_EN
    snap_lo_d    = snap_lo_q;
    snap_val_d   = snap_val_q;
    snap_vld_d   = 1'b0;
`endif
    case (state_q)
      IDLE: if (start && !stop) begin
        state_d  = WR_PL;
        period_d = new_per;
        cnt_d    = '0;
      end
      RUN: begin
        pend_start_d = 1'b0;
        pend_stop_d  = 1'b0;
        if (stop || pend_stop_q) state_d = WR_STOP;
        else if (start || pend_start_q) begin
          state_d  = WR_PL;
          period_d = start ? new_per : pend_per_q;
          cnt_d    = '0;
        end else if (tm.tm_irq) begin
          state_d = WR_CLR;
          cnt_d   = cnt_q + 1'b1;
        end
`ifdef NIOS32_TIMER_HOST_SNAPSHOT_EN
        else if (snap_req) state_d = SNAP_WR;
`endif
      end
      WR_PL:   state_d = WR_PH;
      WR_PH:   state_d = WR_CTRL;
      WR_CTRL: state_d = RUN;
      WR_CLR:  state_d = HOLD;
      HOLD:    state_d = RUN;
      WR_STOP: state_d = IDLE;
`ifdef NIOS32_TIMER_HOST_SNAPSHOT_EN
      SNAP_WR: state_d = SNAP_RL;
      SNAP_RL: state_d = SNAP_RH;
      SNAP_RH: begin
        state_d   = SNAP_CAP;
        snap_lo_d = tm.tm_readdata;
      end
      SNAP_CAP: begin
        state_d    = RUN;
        snap_val_d = {tm.tm_readdata, snap_lo_q};
        snap_vld_d = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && state_q != RUN && state_q != WR_STOP) begin
      if (stop) begin
        pend_stop_d  = 1'b1;
        pend_start_d = 1'b0;
      end else if (start && !pend_stop_q) begin
        pend_start_d = 1'b1;
        pend_per_d   = new_per;
      end
    end
  end

  // Outputs decoded from the next state so every bus/status output comes straight from a flop.
  always_comb begin
    addr_d    = '0;
    cs_d      = 1'b0;
    wn_d      = 1'b1;
    wd_d      = '0;
    running_d = 1'b0;
    case (state_d)
      WR_PL:   begin addr_d = 3'd2; cs_d = 1'b1; wn_d = 1'b0; wd_d = period_d[15:0];  end
      WR_PH:   begin addr_d = 3'd3; cs_d = 1'b1; wn_d = 1'b0; wd_d = period_d[31:16]; end
      WR_CTRL: begin addr_d = 3'd1; cs_d = 1'b1; wn_d = 1'b0; wd_d = 16'h0007;        end
      WR_STOP: begin addr_d = 3'd1; cs_d = 1'b1; wn_d = 1'b0; wd_d = 16'h0008;        end
      WR_CLR:  begin addr_d = 3'd0; cs_d = 1'b1; wn_d = 1'b0; running_d = 1'b1;       end
      RUN, HOLD: running_d = 1'b1;
`ifdef NIOS32_TIMER_HOST_SNAPSHOT_EN
      SNAP_WR: begin addr_d = 3'd4; cs_d = 1'b1; wn_d = 1'b0; running_d = 1'b1;       end
      SNAP_RL: begin addr_d = 3'd4; cs_d = 1'b1; running_d = 1'b1;                    end
      SNAP_RH: begin addr_d = 3'd5; cs_d = 1'b1; running_d = 1'b1;                    end
      SNAP_CAP: running_d = 1'b1;
`endif
      default: ;
    endcase
    tick_d = (state_d == WR_CLR);
    busy_d = (state_d != IDLE) && (state_d != RUN);
  end

  assign tm.tm_address    = addr_q;
  assign tm.tm_chipselect = cs_q;
  assign tm.tm_write_n    = wn_q;
  assign tm.tm_writedata  = wd_q;
  assign tick             = tick_q;
  assign tick_count       = cnt_q;
  assign running          = running_q;
  assign busy             = busy_q;
`ifdef NIOS32_TIMER_HOST_SNAPSHOT_EN
  assign snap_value       = snap_val_q;
  assign snap_valid       = snap_vld_q;
`endif

endmodule

// File: tb/tb_nios32_timer_host.sv
// Directed bench: nios32_timer_host driving a small behavioural interval-timer model.
module tb_nios32_timer_host;
  localparam int          TW   = 4;
  localparam logic [31:0] DEFP = 32'd19;

  logic clk = 1'b0, reset_n = 1'b1;
  logic start = 1'b0, stop = 1'b0, use_default = 1'b0;
  logic [31:0] period_in = '0;
  logic tick, running, busy;
  logic [TW-1:0] tick_count;
  int checks = 0, failures = 0, cyc = 0;
`ifdef NIOS32_TIMER_HOST_SNAPSHOT_EN
  logic snap_req = 1'b0;
  logic [31:0] snap_value;
  logic snap_valid;
`endif

  nios32_timer_host_if tm_if();

  nios32_timer_host #(.DEFAULT_PERIOD(DEFP), .TICK_W(TW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .use_default(use_default), .period_in(period_in),
`ifdef NIOS32_TIMER_HOST_SNAPSHOT_EN
    .snap_req(snap_req), .snap_value(snap_value), .snap_valid(snap_valid),
`endif
    .tm(tm_if.master), .tick(tick), .tick_count(tick_count),
    .running(running), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Interval timer model: down-counter reloading from period, TO status, ITO/CONT/START/STOP control.
  logic [31:0] t_per, t_cnt, t_snap;
  logic t_to, t_ito, t_cont, t_run;
  logic [15:0] t_rd;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_per <= '0; t_cnt <= '0; t_snap <= '0; t_rd <= '0;
      t_to <= 1'b0; t_ito <= 1'b0; t_cont <= 1'b0; t_run <= 1'b0;
    end else begin
      case (tm_if.tm_address)
        3'd0:    t_rd <= {14'd0, t_run, t_to};
        3'd1:    t_rd <= {13'd0, t_cont, t_ito, 1'b0};
        3'd2:    t_rd <= t_per[15:0];
        3'd3:    t_rd <= t_per[31:16];
        3'd4:    t_rd <= t_snap[15:0];
        3'd5:    t_rd <= t_snap[31:16];
        default: t_rd <= '0;
      endcase
      if (t_run) begin
        if (t_cnt == 0) begin
          t_to <= 1'b1; t_cnt <= t_per;
          if (!t_cont) t_run <= 1'b0;
        end else t_cnt <= t_cnt - 1;
      end
      if (tm_if.tm_chipselect && !tm_if.tm_write_n) begin
        case (tm_if.tm_address)
          3'd0: t_to <= 1'b0;
          3'd1: begin
            t_ito <= tm_if.tm_writedata[0]; t_cont <= tm_if.tm_writedata[1];
            if (tm_if.tm_writedata[2]) begin t_run <= 1'b1; t_cnt <= t_per; end
            if (tm_if.tm_writedata[3]) t_run <= 1'b0;
          end
          3'd2: begin t_per[15:0]  <= tm_if.tm_writedata; t_run <= 1'b0; end
          3'd3: begin t_per[31:16] <= tm_if.tm_writedata; t_run <= 1'b0; end
          3'd4, 3'd5: t_snap <= t_cnt;
          default: ;
        endcase
      end
    end
  end
  assign tm_if.tm_readdata = t_rd;
  assign tm_if.tm_irq      = t_to & t_ito;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bus();
    return {11'd0, tm_if.tm_chipselect, tm_if.tm_write_n, tm_if.tm_address, tm_if.tm_writedata};
  endfunction

  function automatic logic [31:0] wr(input logic [2:0] a, input logic [15:0] d);
    return {11'd0, 1'b1, 1'b0, a, d};
  endfunction

  localparam logic [31:0] IDLE_BUS = {11'd0, 1'b0, 1'b1, 3'd0, 16'd0};

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] p, input logic ud);
    period_in = p; use_default = ud; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_tick(input string tag, output int at);
    int n;
    n = 0;
    step();
    while (tick !== 1'b1 && n < 200) begin step(); n++; end
    at = cyc;
    chk(tag, {31'd0, tick}, 32'd1);
  endtask

  initial begin
    int t1, t2, nt;
    #2 reset_n = 1'b0;
    step(2);
    chk("rst_bus", bus(), IDLE_BUS);
    chk("rst_flags", {tick, running, busy}, 32'd0);
    chk("rst_count", tick_count, 32'd0);
    reset_n = 1'b1;
    step();

    // Program period 9: PL, PH, CTRL on consecutive cycles, then RUN
    pulse_start(32'd9, 1'b0);
    chk("seq_pl", bus(), wr(3'd2, 16'h0009));
    chk("seq_busy", busy, 32'd1);
    step();
    chk("seq_ph", bus(), wr(3'd3, 16'h0000));
    step();
    chk("seq_ctrl", bus(), wr(3'd1, 16'h0007));
    step();
    chk("seq_run", {running, busy, tm_if.tm_chipselect}, 32'b100);

    wait_tick("tick1", t1);
    chk("tick1_clr", bus(), wr(3'd0, 16'h0000));
    wait_tick("tick2", t2);
    chk("tick_interval", t2 - t1, 32'd10);
    for (int i = 3; i <= 5; i++) begin
      wait_tick("tickn", t2);
      chk("tickn_clr", bus(), wr(3'd0, 16'h0000));
    end
    chk("count5", tick_count, 32'd5);
    step();
    chk("irq_low", tm_if.tm_irq, 32'd0);
    step();

    // Stop from RUN, then silence
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop_wr", bus(), wr(3'd1, 16'h0008));
    step();
    chk("stop_idle", {running, busy, tm_if.tm_chipselect}, 32'b000);
    nt = 0;
    for (int i = 0; i < 100; i++) begin step(); nt += int'(tick); end
    chk("no_ticks", nt, 32'd0);
    chk("count_held", tick_count, 32'd5);

    // start+stop together in IDLE: nothing happens
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("ss_idle", {busy, tm_if.tm_chipselect}, 32'b00);

    // start+stop together in RUN: stop wins
    pulse_start(32'd9, 1'b0);
    step(3);
    chk("ss_run_pre", {running, busy}, 32'b10);
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("ss_run_stop", bus(), wr(3'd1, 16'h0008));
    step();

    // stop during WR_PL is held until RUN entry
    pulse_start(32'd9, 1'b0);
    stop = 1'b1; step(); stop = 1'b0;
    step(2);
    chk("pend_stop_run", running, 32'd1);
    step();
    chk("pend_stop_wr", bus(), wr(3'd1, 16'h0008));
    step();

    // start during WR_PL is held and re-programs with its own period
    pulse_start(32'd9, 1'b0);
    period_in = 32'd5; start = 1'b1; step(); start = 1'b0;
    step(2);
    step();
    chk("pend_start_pl", bus(), wr(3'd2, 16'h0005));
    step(3);
    stop = 1'b1; step(); stop = 1'b0;
    step();

    // Reset during WR_PH abandons the sequence
    pulse_start(32'd9, 1'b0);
    step();
    chk("rst_mid_ph", bus(), wr(3'd3, 16'h0000));
    reset_n = 1'b0;
    #1;
    chk("rst_mid_bus", bus(), IDLE_BUS);
    chk("rst_mid_flags", {running, busy}, 32'd0);
    step(2);
    reset_n = 1'b1;
    step(3);
    chk("rst_mid_quiet", bus(), IDLE_BUS);

    // Default period and tick_count wrap at 2^TW-1
    pulse_start(32'd1234, 1'b1);
    chk("dflt_pl", bus(), wr(3'd2, 16'd19));
    step(3);
    wait_tick("dflt_t1", t1);
    wait_tick("dflt_t2", t2);
    chk("dflt_interval", t2 - t1, 32'd20);
    for (int i = 3; i <= 15; i++) wait_tick("wrap_tick", t2);
    chk("count_max", tick_count, 32'd15);
    wait_tick("wrap_last", t2);
    chk("count_wrap", tick_count, 32'd0);
    step(2);
    stop = 1'b1; step(); stop = 1'b0;
    step();

`ifdef NIOS32_TIMER_HOST_SNAPSHOT_EN
    snap_req = 1'b1; step(); snap_req = 1'b0;
    chk("snap_idle_ignored", {busy, tm_if.tm_chipselect}, 32'b00);
    pulse_start(32'h0001_0000, 1'b0);
    step(3);
    snap_req = 1'b1; step(); snap_req = 1'b0;
    chk("snap_wr", bus(), wr(3'd4, 16'h0000));
    nt = 0;
    while (snap_valid !== 1'b1 && nt < 10) begin step(); nt++; end
    chk("snap_valid", snap_valid, 32'd1);
    chk("snap_range", {31'd0, (snap_value <= 32'h0001_0000) && (snap_value > 32'h0000_FFE0)}, 32'd1);
    step();
    chk("snap_valid_pulse", snap_valid, 32'd0);
    chk("snap_back_run", {running, busy}, 32'b10);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
